fp8_seg_display: RTL and testbench
==================================

// Module: fp8_seg_display
// PURPOSE
//  Output end of the FP8 adder pin interface. Takes one 8-bit FP8 (E4M3) adder result
//  through a valid/ready handshake and presents it on the 7-segment pins (uo_out[6:0]).
//  The byte is shown as two time-multiplexed hex digits with blank gaps between them.
//  The decimal point (uo_out[7]) marks the high nibble. The display loops until a new
//  result is accepted or the display is cleared.
// PARAMETERS
//  DWELL_CYCLES  1000  clock cycles each digit is lit; legal range >= 1
//  BLANK_CYCLES  250   clock cycles of blank display after each digit; legal range >= 1
// PORTS
//  clk           in   1  clock; all state updates on posedge
//  rst           in   1  asynchronous, active-high reset
//  result_in     in   8  FP8 E4M3 result {sign, exp[3:0], man[2:0]}
//  result_valid  in   1  result_in is valid this cycle
//  result_ready  out  1  block accepts result_in this cycle
//  clear         in   1  synchronous; return to IDLE and blank the display
//  segments      out  7  {g,f,e,d,c,b,a}; active-high; registered
//  dp            out  1  decimal point; 1 while the high nibble is shown; registered
//  busy          out  1  1 in every state except IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, segments=7'h00, dp=0, busy=0, counter=0, held value=8'h00.
//  States: IDLE -> SHOW_HI -> GAP_HI -> SHOW_LO -> GAP_LO -> SHOW_HI (loops).
//  result_ready=1 only in IDLE and GAP_LO. It is driven combinationally from state and
//    is forced to 0 while clear=1.
//  Accept: result_valid && result_ready at a posedge. On that edge:
//    capture result_in; counter <= 0; state <= SHOW_HI.
//    The new digit appears on segments in the first cycle after the accept edge.
//    Acceptance in GAP_LO preempts the rest of the gap.
//  SHOW_HI / SHOW_LO last exactly DWELL_CYCLES cycles. GAP_HI / GAP_LO last exactly
//    BLANK_CYCLES cycles. The counter resets to 0 on every state change.
//  Display value per state:
//    SHOW_HI: hex(held[7:4]), dp=1.
//    SHOW_LO: hex(held[3:0]), dp=0.
//    GAP_HI, GAP_LO, IDLE: segments=0, dp=0.
//  NaN (held[6:0]==7'h7F, either sign): both SHOW states display dash 7'h40 instead of hex.
//  Hex table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E
//    E=79 F=71.
//  clear=1 at a posedge: state <= IDLE, segments <= 0, dp <= 0. clear has priority over
//    an accept in the same cycle; that result is not consumed.
//  result_valid while result_ready=0: ignored. The producer must hold result_in and
//    result_valid until it sees ready.
//  Counter width = $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1). The counter never wraps;
//    it is reset by each transition.
//  rst asserted mid-display: all outputs take reset values immediately (asynchronous).
//    Operation resumes in IDLE on the first edge after deassertion.
//  DWELL_CYCLES=1 or BLANK_CYCLES=1: the corresponding state lasts exactly one cycle.
// STRUCTURE
//  Package fp8_pkg:
//    typedef fp8_t (packed struct: sign, exp[3:0], man[2:0]);
//    constant FP8_NAN_MAG = 7'h7F;
//    typedef seg7_t = logic [6:0];
//    constants SEG_BLANK = 7'h00 and SEG_DASH = 7'h40;
//    state enum disp_state_e.
//  Sub-module hex_to_seg7 (combinational, 4-bit nibble -> seg7_t). Shared with other
//    7-segment users.
//  Top level: FSM, dwell counter, held-value register, output registers.
// TESTING (DWELL_CYCLES=4, BLANK_CYCLES=2)
//  1. Assert then release rst -> segments=00, dp=0, busy=0, result_ready=1.
//  2. Drive 8'h3C with valid for 1 cycle -> sequence:
//       4 cycles 4F with dp=1; 2 cycles 00; 4 cycles 39 with dp=0; 2 cycles 00;
//       then 4F again (loop).
//  3. Drive 8'hFF (NaN, sign=1) -> 4 cycles 40 with dp=1, 2 cycles 00,
//     4 cycles 40 with dp=0.
//  4. While showing 3C, hold 8'hA5 valid from SHOW_HI onward -> ready stays 0 until
//     GAP_LO; accept occurs in the first GAP_LO cycle; next cycle segments=77 with dp=1.
//  5. In IDLE, assert clear and valid(8'h12) together -> not accepted; stays IDLE,
//     segments=00. The next cycle with valid only -> segments=06, dp=1.
//  6. Assert rst asynchronously (between edges) during SHOW_LO -> segments=00, dp=0,
//     busy=0 before the next posedge; idle after release.

Source files
------------

// File: rtl/fp8_pkg.sv
// Shared types and constants for the FP8 result display path.
package fp8_pkg;

  typedef struct packed {
    logic       sign;
    logic [3:0] exp;
    logic [2:0] man;
  } fp8_t;

  localparam logic [6:0] FP8_NAN_MAG = 7'h7F;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;
  localparam seg7_t SEG_DASH  = 7'h40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHOW_HI = 3'd1,
    ST_GAP_HI  = 3'd2,
    ST_SHOW_LO = 3'd3,
    ST_GAP_LO  = 3'd4
  } disp_state_e;

  // E4M3 has a single NaN magnitude; the sign bit is ignored.
  function automatic logic is_nan(input fp8_t v);
    return {v.exp, v.man} == FP8_NAN_MAG;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment pattern {g,f,e,d,c,b,a}, active-high.
module hex_to_seg7
  import fp8_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fp8_seg_display.sv
// Shows an accepted FP8 result as two time-multiplexed hex digits with blank gaps;
// the decimal point marks the high nibble.
module fp8_seg_display
  import fp8_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result_in,
  input  logic       result_valid,
  output logic       result_ready,
  input  logic       clear,
  output logic [6:0] segments,
  output logic       dp,
  output logic       busy
);

  localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  disp_state_e      state, next_state;
  logic [CNT_W-1:0] cnt;
  fp8_t             held, held_next;
  logic             accept;
  seg7_t            seg_hi, seg_lo, seg_next;
  logic             dp_next;

  assign accept    = result_valid && result_ready;
  assign held_next = accept ? fp8_t'(result_in) : held;

  hex_to_seg7 u_hex_hi (.nibble(held_next[7:4]), .seg(seg_hi));
  hex_to_seg7 u_hex_lo (.nibble(held_next[3:0]), .seg(seg_lo));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = ST_IDLE;
    end else if (accept) begin
      next_state = ST_SHOW_HI;
    end else begin
      unique case (state)
        ST_SHOW_HI: if (cnt == DWELL_LAST) next_state = ST_GAP_HI;
        ST_GAP_HI:  if (cnt == BLANK_LAST) next_state = ST_SHOW_LO;
        ST_SHOW_LO: if (cnt == DWELL_LAST) next_state = ST_GAP_LO;
        ST_GAP_LO:  if (cnt == BLANK_LAST) next_state = ST_SHOW_HI;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  // Display values are computed from the post-edge state and value so the
  // registered pins line up with the state they belong to.
  always_comb begin
    result_ready = 1'b0;
    seg_next     = SEG_BLANK;
    dp_next      = 1'b0;
    if ((state == ST_IDLE) || (state == ST_GAP_LO)) result_ready = !clear;
    unique case (next_state)
      ST_SHOW_HI: begin
        seg_next = is_nan(held_next) ? SEG_DASH : seg_hi;
        dp_next  = 1'b1;
      end
      ST_SHOW_LO: seg_next = is_nan(held_next) ? SEG_DASH : seg_lo;
      default: begin
        seg_next = SEG_BLANK;
        dp_next  = 1'b0;
      end
    endcase
  end

  // Counter restarts on every transition and idles at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((next_state != state) || (next_state == ST_IDLE)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held     <= '0;
      segments <= SEG_BLANK;
      dp       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      held     <= held_next;
      segments <= seg_next;
      dp       <= dp_next;
      busy     <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fp8_seg_display.sv
// Directed bench for fp8_seg_display: per-cycle vector table plus reset and
// single-cycle-timing sequences.
module tb_fp8_seg_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] result_in = 8'h00;
  logic       result_valid = 1'b0;
  logic       clear = 1'b0;
  logic       result_ready;
  logic [6:0] segments;
  logic       dp;
  logic       busy;

  logic [7:0] result_in2 = 8'h00;
  logic       result_valid2 = 1'b0;
  logic       clear2 = 1'b0;
  logic       result_ready2;
  logic [6:0] segments2;
  logic       dp2;
  logic       busy2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp8_seg_display #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .result_in(result_in), .result_valid(result_valid),
    .result_ready(result_ready), .clear(clear), .segments(segments), .dp(dp), .busy(busy)
  );

  fp8_seg_display #(.DWELL_CYCLES(1), .BLANK_CYCLES(1)) dut_min (
    .clk(clk), .rst(rst), .result_in(result_in2), .result_valid(result_valid2),
    .result_ready(result_ready2), .clear(clear2), .segments(segments2), .dp(dp2), .busy(busy2)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       clr;
    logic       rdy;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic v, input logic [7:0] d, input logic c,
                     input logic r, input logic [6:0] s, input logic p, input logic b);
    vec_t e;
    e.valid = v; e.data = d; e.clr = c; e.rdy = r; e.seg = s; e.dp = p; e.busy = b;
    for (int k = 0; k < n; k++) vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 0x3C: four 4F with dp, gap, four 39, gap, loop
    add(1, 1, 8'h3C, 0, 1, 7'h4F, 1, 1);
    add(3, 0, 8'h00, 0, 0, 7'h4F, 1, 1);
    add(2, 0, 8'h00, 0, 0, 7'h00, 0, 1);
    add(4, 0, 8'h00, 0, 0, 7'h39, 0, 1);
    add(1, 0, 8'h00, 0, 0, 7'h00, 0, 1);
    add(1, 0, 8'h00, 0, 1, 7'h00, 0, 1);
    add(1, 0, 8'h00, 0, 1, 7'h4F, 1, 1);
    add(1, 0, 8'h00, 0, 0, 7'h4F, 1, 1);
    // clear, then negative NaN shows dashes
    add(1, 0, 8'h00, 1, 0, 7'h00, 0, 0);
    add(1, 1, 8'hFF, 0, 1, 7'h40, 1, 1);
    add(3, 0, 8'h00, 0, 0, 7'h40, 1, 1);
    add(2, 0, 8'h00, 0, 0, 7'h00, 0, 1);
    add(4, 0, 8'h00, 0, 0, 7'h40, 0, 1);
    // 0xA5 held from SHOW_HI onward, accepted in first GAP_LO cycle
    add(1, 0, 8'h00, 1, 0, 7'h00, 0, 0);
    add(1, 1, 8'h3C, 0, 1, 7'h4F, 1, 1);
    add(3, 1, 8'hA5, 0, 0, 7'h4F, 1, 1);
    add(2, 1, 8'hA5, 0, 0, 7'h00, 0, 1);
    add(4, 1, 8'hA5, 0, 0, 7'h39, 0, 1);
    add(1, 1, 8'hA5, 0, 0, 7'h00, 0, 1);
    add(1, 1, 8'hA5, 0, 1, 7'h77, 1, 1);
    add(3, 0, 8'h00, 0, 0, 7'h77, 1, 1);
    add(2, 0, 8'h00, 0, 0, 7'h00, 0, 1);
    add(1, 0, 8'h00, 0, 0, 7'h6D, 0, 1);
    // clear wins over a same-cycle accept in IDLE
    add(1, 1, 8'h12, 1, 0, 7'h00, 0, 0);
    add(1, 1, 8'h12, 1, 0, 7'h00, 0, 0);
    add(1, 1, 8'h12, 0, 1, 7'h06, 1, 1);
    add(3, 0, 8'h00, 0, 0, 7'h06, 1, 1);
    add(2, 0, 8'h00, 0, 0, 7'h00, 0, 1);
    add(1, 0, 8'h00, 0, 0, 7'h5B, 0, 1);

    // Reset state while rst is held, then after release
    #12;
    check("rst.seg", 8'(segments), 8'h00);
    check("rst.dp", 8'(dp), 8'h00);
    check("rst.busy", 8'(busy), 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("idle.ready", 8'(result_ready), 8'h01);
    check("idle.seg", 8'(segments), 8'h00);

    foreach (vecs[i]) begin
      result_valid = vecs[i].valid;
      result_in    = vecs[i].data;
      clear        = vecs[i].clr;
      #1;
      check($sformatf("v%0d.ready", i), 8'(result_ready), 8'(vecs[i].rdy));
      tick();
      check($sformatf("v%0d.seg", i), 8'(segments), 8'(vecs[i].seg));
      check($sformatf("v%0d.dp", i), 8'(dp), 8'(vecs[i].dp));
      check($sformatf("v%0d.busy", i), 8'(busy), 8'(vecs[i].busy));
    end
    result_valid = 1'b0;
    clear = 1'b0;

    // Asynchronous reset between edges during SHOW_LO
    #3 rst = 1'b1;
    #1;
    check("arst.seg", 8'(segments), 8'h00);
    check("arst.dp", 8'(dp), 8'h00);
    check("arst.busy", 8'(busy), 8'h00);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst.ready", 8'(result_ready), 8'h01);
    tick();
    check("post_rst.seg", 8'(segments), 8'h00);
    check("post_rst.busy", 8'(busy), 8'h00);

    // One-cycle dwell and blank: 0x80 -> 7F, blank, 3F, blank, 7F
    result_valid2 = 1'b1;
    result_in2    = 8'h80;
    #1;
    check("min.ready_idle", 8'(result_ready2), 8'h01);
    tick();
    result_valid2 = 1'b0;
    check("min.hi.seg", 8'(segments2), 8'h7F);
    check("min.hi.dp", 8'(dp2), 8'h01);
    tick();
    check("min.gap_hi.seg", 8'(segments2), 8'h00);
    tick();
    check("min.lo.seg", 8'(segments2), 8'h3F);
    check("min.lo.dp", 8'(dp2), 8'h00);
    tick();
    check("min.gap_lo.seg", 8'(segments2), 8'h00);
    check("min.gap_lo.ready", 8'(result_ready2), 8'h01);
    tick();
    check("min.loop.seg", 8'(segments2), 8'h7F);
    check("min.loop.dp", 8'(dp2), 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
